button_fifo_ctrl: RTL and testbench
===================================

Name: button_fifo_ctrl

Overview:
- Sequences the push-button user interface of the UART-FIFO design.
- Takes debounced positive-edge pulses from a "write" button and a "read" button.
  - Write pushes the switch value into the FIFO.
  - Read pops one FIFO word and hands it to the UART transmitter via a start/done handshake.
- Arbitrates between the two button requests round-robin and reports overflow/underflow attempts.

Parameters:
- DATA_BITS, 8, width of switch data, FIFO words and UART TX byte.

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset, sampled on rising clk
- wr_pulse  in  1  one-cycle pulse from write-button conditioning (p_edge)
- rd_pulse  in  1  one-cycle pulse from read-button conditioning (p_edge)
- sw_data  in  DATA_BITS  switch value to push
- fifo_full  in  1  FIFO full flag
- fifo_empty  in  1  FIFO empty flag
- fifo_wr_en  out  1  one-cycle FIFO write strobe
- fifo_w_data  out  DATA_BITS  FIFO write data, valid while fifo_wr_en=1
- fifo_rd_en  out  1  one-cycle FIFO read strobe
- fifo_r_data  in  DATA_BITS  FIFO read data, valid the cycle after fifo_rd_en
- tx_start  out  1  one-cycle UART TX start
- tx_din  out  DATA_BITS  byte to transmit, held stable from tx_start until tx_done_tick
- tx_done_tick  in  1  UART TX frame complete
- busy  out  1  state != IDLE or any request pending
- ovf_tick  out  1  one-cycle pulse: write refused, FIFO full
- unf_tick  out  1  one-cycle pulse: read refused, FIFO empty
- err_count  out  8  saturating count of ovf+unf events

Behaviour:
- Reset (reset_n=0 at a rising edge):
  - State returns to IDLE.
  - wr_pend, rd_pend and all outputs go to 0; tx_din=0; err_count=0; last_served=READ, so write wins the first tie.
  - An in-flight UART frame is not aborted; a tx_done_tick arriving after reset is ignored.
- Request latching:
  - wr_pulse sets wr_pend; rd_pulse sets rd_pend (one-deep each). Extra pulses while a request is pending merge into it.
  - A set and a grant-clear in the same cycle: set wins, so the request stays pending.
- States: IDLE, WRITE, READ, LOAD, SEND, WAIT_DONE. All outputs are registered/Moore.
- IDLE arbitration:
  - Only wr_pend: grant write. Only rd_pend: grant read.
  - Both pending: grant the type opposite to last_served. last_served updates on every grant, including refused ones.
- Write grant:
  - The grant clears wr_pend.
  - If fifo_full: ovf_tick=1 for the next cycle, err_count+1, stay IDLE.
  - Else: capture sw_data into fifo_w_data and go to WRITE; fifo_wr_en=1 for exactly one cycle, then IDLE.
- Read grant:
  - The grant clears rd_pend.
  - If fifo_empty: unf_tick=1 for the next cycle, err_count+1, stay IDLE.
  - Else: READ (fifo_rd_en=1, one cycle), then LOAD (tx_din <= fifo_r_data), then SEND (tx_start=1, one cycle), then WAIT_DONE until tx_done_tick, then IDLE.
- Latency, with the pulse in cycle N:
  - Pending bit visible at N+1.
  - Write: fifo_wr_en at N+2.
  - Read: fifo_rd_en at N+2, tx_start at N+4.
  - Error: ovf_tick/unf_tick at N+2.
- Flag sampling: fifo_full/fifo_empty are sampled only in the IDLE grant cycle.
- tx_done_tick is ignored outside WAIT_DONE. While in READ/LOAD/SEND/WAIT_DONE, new pulses are latched but not served.
- err_count saturates at 255. An ovf and an unf can never both occur in the same cycle.

Test Plan:
- Reset, then wr_pulse with sw_data=8'hA5 and fifo_full=0 -> fifo_wr_en high for 1 cycle exactly 2 cycles after the pulse, with fifo_w_data=8'hA5; busy drops the following cycle.
- rd_pulse with fifo_empty=0 and fifo_r_data=8'h3C -> fifo_rd_en at N+2 and tx_start at N+4 with tx_din=8'h3C. tx_din stays stable for 100 cycles until tx_done_tick; state is IDLE the cycle after.
- wr_pulse and rd_pulse in the same cycle after reset -> write served first, then the read. Repeat the tie -> read served first.
- wr_pulse with fifo_full=1 -> no fifo_wr_en, ovf_tick high 1 cycle at N+2, err_count=1. rd_pulse with fifo_empty=1 -> unf_tick, err_count=2. Then 300 refused requests -> err_count=255.
- wr_pulse during WAIT_DONE -> held pending; fifo_wr_en occurs 2 cycles after tx_done_tick returns the FSM to IDLE.
- reset_n=0 during WAIT_DONE -> all outputs 0 next cycle; a later tx_done_tick causes no transition.

Source files
------------

// File: rtl/button_fifo_ctrl_if.sv
// Handshake bundle between the push-button sequencer and its FIFO / UART TX neighbours.
// The master side is the sequencer; the slave side is the surrounding datapath.
interface button_fifo_ctrl_if #(
  parameter int unsigned DATA_BITS = 8
);
  localparam int unsigned ERR_W = 8;

  logic                 wr_pulse;
  logic                 rd_pulse;
  logic [DATA_BITS-1:0] sw_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_wr_en;
  logic [DATA_BITS-1:0] fifo_w_data;
  logic                 fifo_rd_en;
  logic [DATA_BITS-1:0] fifo_r_data;
  logic                 tx_start;
  logic [DATA_BITS-1:0] tx_din;
  logic                 tx_done_tick;
  logic                 busy;
  logic                 ovf_tick;
  logic                 unf_tick;
  logic [ERR_W-1:0]     err_count;

  modport master (
    input  wr_pulse, rd_pulse, sw_data, fifo_full, fifo_empty, fifo_r_data, tx_done_tick,
    output fifo_wr_en, fifo_w_data, fifo_rd_en, tx_start, tx_din, busy, ovf_tick, unf_tick,
           err_count
  );

  modport slave (
    output wr_pulse, rd_pulse, sw_data, fifo_full, fifo_empty, fifo_r_data, tx_done_tick,
    input  fifo_wr_en, fifo_w_data, fifo_rd_en, tx_start, tx_din, busy, ovf_tick, unf_tick,
           err_count
  );
endinterface

// File: rtl/button_fifo_ctrl.sv
// Push-button sequencer: write button pushes switches into the FIFO, read button pops a
// word and sends it over UART TX. Round-robin arbitration, refused requests are counted.
module button_fifo_ctrl #(
  parameter int unsigned DATA_BITS = 8
) (
  input  logic                clk,
  input  logic                reset_n,
  button_fifo_ctrl_if.master  bus
);
  localparam int unsigned ERR_W = 8;

  typedef enum logic [2:0] {IDLE, WRITE, READ, LOAD, SEND, WAIT_DONE} state_t;
  typedef enum logic {SRV_WRITE, SRV_READ} srv_t;

  state_t               state, state_d;
  srv_t                 last_served, last_served_d;
  logic                 wr_pend, wr_pend_d;
  logic                 rd_pend, rd_pend_d;
  logic                 fifo_wr_en_q, fifo_wr_en_d;
  logic [DATA_BITS-1:0] fifo_w_data_q, fifo_w_data_d;
  logic                 fifo_rd_en_q, fifo_rd_en_d;
  logic                 tx_start_q, tx_start_d;
  logic [DATA_BITS-1:0] tx_din_q, tx_din_d;
  logic                 busy_q, busy_d;
  logic                 ovf_q, ovf_d;
  logic                 unf_q, unf_d;
  logic [ERR_W-1:0]     err_q, err_d;
  logic                 grant_wr, grant_rd;

  // Next state, request bookkeeping and next registered outputs.
  always_comb begin
    state_d       = state;
    last_served_d = last_served;
    wr_pend_d     = wr_pend | bus.wr_pulse;
    rd_pend_d     = rd_pend | bus.rd_pulse;
    fifo_w_data_d = fifo_w_data_q;
    tx_din_d      = tx_din_q;
    ovf_d         = 1'b0;
    unf_d         = 1'b0;
    err_d         = err_q;
    grant_wr      = 1'b0;
    grant_rd      = 1'b0;

    case (state)
      IDLE: begin
        // On a tie the request type not served last time wins.
        if (wr_pend && (!rd_pend || last_served == SRV_READ)) grant_wr = 1'b1;
        else if (rd_pend)                                      grant_rd = 1'b1;

        if (grant_wr) begin
          last_served_d = SRV_WRITE;
          wr_pend_d     = bus.wr_pulse;
          if (bus.fifo_full) begin
            ovf_d = 1'b1;
          end else begin
            fifo_w_data_d = bus.sw_data;
            state_d       = WRITE;
          end
        end else if (grant_rd) begin
          last_served_d = SRV_READ;
          rd_pend_d     = bus.rd_pulse;
          if (bus.fifo_empty) unf_d = 1'b1;
          else                state_d = READ;
        end
      end
      WRITE:     state_d = IDLE;
      READ:      state_d = LOAD;
      LOAD: begin
        tx_din_d = bus.fifo_r_data;
        state_d  = SEND;
      end
      SEND:      state_d = WAIT_DONE;
      WAIT_DONE: if (bus.tx_done_tick) state_d = IDLE;
      default:   state_d = IDLE;
    endcase

    if ((ovf_d || unf_d) && err_q != {ERR_W{1'b1}}) err_d = err_q + ERR_W'(1);

    fifo_wr_en_d = (state_d == WRITE);
    fifo_rd_en_d = (state_d == READ);
    tx_start_d   = (state_d == SEND);
    busy_d       = (state_d != IDLE) || wr_pend_d || rd_pend_d;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      last_served   <= SRV_READ;
      wr_pend       <= 1'b0;
      rd_pend       <= 1'b0;
      fifo_wr_en_q  <= 1'b0;
      fifo_w_data_q <= '0;
      fifo_rd_en_q  <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_din_q      <= '0;
      busy_q        <= 1'b0;
      ovf_q         <= 1'b0;
      unf_q         <= 1'b0;
      err_q         <= '0;
    end else begin
      state         <= state_d;
      last_served   <= last_served_d;
      wr_pend       <= wr_pend_d;
      rd_pend       <= rd_pend_d;
      fifo_wr_en_q  <= fifo_wr_en_d;
      fifo_w_data_q <= fifo_w_data_d;
      fifo_rd_en_q  <= fifo_rd_en_d;
      tx_start_q    <= tx_start_d;
      tx_din_q      <= tx_din_d;
      busy_q        <= busy_d;
      ovf_q         <= ovf_d;
      unf_q         <= unf_d;
      err_q         <= err_d;
    end
  end

  assign bus.fifo_wr_en  = fifo_wr_en_q;
  assign bus.fifo_w_data = fifo_w_data_q;
  assign bus.fifo_rd_en  = fifo_rd_en_q;
  assign bus.tx_start    = tx_start_q;
  assign bus.tx_din      = tx_din_q;
  assign bus.busy        = busy_q;
  assign bus.ovf_tick    = ovf_q;
  assign bus.unf_tick    = unf_q;
  assign bus.err_count   = err_q;
endmodule

// File: tb/tb_button_fifo_ctrl.sv
// Bench for button_fifo_ctrl: directed latency/arbitration scenarios, then random single
// requests against a queue-based FIFO model and a saturating error counter.
module tb_button_fifo_ctrl;
  localparam int unsigned DATA_BITS = 8;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  button_fifo_ctrl_if #(.DATA_BITS(DATA_BITS)) bus ();
  button_fifo_ctrl #(.DATA_BITS(DATA_BITS)) dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int exp_err = 0;
  logic [7:0] exp_q[$];

  // FIFO stand-in: either forced flags/data or a small queue reacting to the strobes.
  bit use_emu = 1'b0;
  logic dir_full = 1'b0, dir_empty = 1'b0;
  logic [7:0] dir_rdata = 8'h00;
  logic [7:0] emu_q[$];
  logic [7:0] emu_rdata = 8'h00;
  int emu_cnt = 0;

  always @(posedge clk) begin
    logic [7:0] tmp;
    if (!reset_n || !use_emu) begin
      emu_q.delete();
      emu_cnt <= 0;
    end else begin
      if (bus.fifo_wr_en && emu_q.size() < DEPTH) emu_q.push_back(bus.fifo_w_data);
      if (bus.fifo_rd_en && emu_q.size() > 0) begin
        tmp = emu_q.pop_front();
        emu_rdata <= tmp;
      end
      emu_cnt <= emu_q.size();
    end
  end

  assign bus.fifo_full   = use_emu ? (emu_cnt == DEPTH) : dir_full;
  assign bus.fifo_empty  = use_emu ? (emu_cnt == 0)     : dir_empty;
  assign bus.fifo_r_data = use_emu ? emu_rdata          : dir_rdata;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_wr_en"}, 32'(bus.fifo_wr_en), 0);
    chk({tag, "_w_data"}, 32'(bus.fifo_w_data), 0);
    chk({tag, "_rd_en"}, 32'(bus.fifo_rd_en), 0);
    chk({tag, "_tx_start"}, 32'(bus.tx_start), 0);
    chk({tag, "_tx_din"}, 32'(bus.tx_din), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_ovf"}, 32'(bus.ovf_tick), 0);
    chk({tag, "_unf"}, 32'(bus.unf_tick), 0);
    chk({tag, "_err"}, 32'(bus.err_count), 0);
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.wr_pulse = 1'b0;
    bus.rd_pulse = 1'b0;
    tick();
    reset_n = 1'b1;
    exp_err = 0;
    exp_q.delete();
  endtask

  // One isolated request; flag = fifo_full for writes, fifo_empty for reads.
  task automatic do_op(input bit is_wr, input logic [7:0] data, input bit flag,
                       input logic [7:0] rexp, input int done_delay);
    if (!use_emu) begin
      dir_full  = is_wr ? flag : 1'b0;
      dir_empty = is_wr ? 1'b0 : flag;
      dir_rdata = rexp;
    end
    bus.sw_data = data;
    if (is_wr) bus.wr_pulse = 1'b1; else bus.rd_pulse = 1'b1;
    tick();  // N+1
    bus.wr_pulse = 1'b0;
    bus.rd_pulse = 1'b0;
    chk("pend_busy", 32'(bus.busy), 1);
    tick();  // N+2
    if (flag) begin
      if (exp_err < 255) exp_err++;
      if (is_wr) chk("ovf_tick", 32'(bus.ovf_tick), 1);
      else       chk("unf_tick", 32'(bus.unf_tick), 1);
      chk("err_count", 32'(bus.err_count), 32'(exp_err));
      chk("refused_no_wr", 32'(bus.fifo_wr_en), 0);
      chk("refused_no_rd", 32'(bus.fifo_rd_en), 0);
      chk("refused_idle", 32'(bus.busy), 0);
      tick();
      chk("ovf_one_cycle", 32'(bus.ovf_tick), 0);
      chk("unf_one_cycle", 32'(bus.unf_tick), 0);
    end else if (is_wr) begin
      chk("wr_en", 32'(bus.fifo_wr_en), 1);
      chk("w_data", 32'(bus.fifo_w_data), 32'(data));
      chk("wr_err_same", 32'(bus.err_count), 32'(exp_err));
      chk("wr_no_ovf", 32'(bus.ovf_tick), 0);
      if (use_emu) exp_q.push_back(data);
      tick();
      chk("wr_en_one_cycle", 32'(bus.fifo_wr_en), 0);
      chk("wr_busy_drop", 32'(bus.busy), 0);
    end else begin
      chk("rd_en", 32'(bus.fifo_rd_en), 1);
      chk("rd_no_unf", 32'(bus.unf_tick), 0);
      tick();
      chk("rd_en_one_cycle", 32'(bus.fifo_rd_en), 0);
      tick();  // N+4
      chk("tx_start", 32'(bus.tx_start), 1);
      chk("tx_din", 32'(bus.tx_din), 32'(rexp));
      if (use_emu) void'(exp_q.pop_front());
      for (int d = 0; d < done_delay; d++) begin
        tick();
        chk("tx_start_one_cycle", 32'(bus.tx_start), 0);
        chk("tx_din_stable", 32'(bus.tx_din), 32'(rexp));
      end
      bus.tx_done_tick = 1'b1;
      tick();
      bus.tx_done_tick = 1'b0;
      chk("done_idle", 32'(bus.busy), 0);
      chk("tx_din_held", 32'(bus.tx_din), 32'(rexp));
    end
  endtask

  // Both buttons in the same cycle.
  task automatic tie(input bit first_wr, input logic [7:0] d, input logic [7:0] r);
    dir_full = 1'b0; dir_empty = 1'b0; dir_rdata = r;
    bus.sw_data = d;
    bus.wr_pulse = 1'b1; bus.rd_pulse = 1'b1;
    tick();
    bus.wr_pulse = 1'b0; bus.rd_pulse = 1'b0;
    tick();  // N+2
    if (first_wr) begin
      chk("tie_w_first_wr", 32'(bus.fifo_wr_en), 1);
      chk("tie_w_first_data", 32'(bus.fifo_w_data), 32'(d));
      chk("tie_w_first_no_rd", 32'(bus.fifo_rd_en), 0);
      tick();
      chk("tie_w_rd_pending", 32'(bus.busy), 1);
      chk("tie_w_gap_rd", 32'(bus.fifo_rd_en), 0);
      tick();
      chk("tie_w_then_rd", 32'(bus.fifo_rd_en), 1);
      tick(); tick();
      chk("tie_w_tx_start", 32'(bus.tx_start), 1);
      chk("tie_w_tx_din", 32'(bus.tx_din), 32'(r));
      tick();
      bus.tx_done_tick = 1'b1;
      tick();
      bus.tx_done_tick = 1'b0;
      chk("tie_w_done", 32'(bus.busy), 0);
    end else begin
      chk("tie_r_first_rd", 32'(bus.fifo_rd_en), 1);
      chk("tie_r_first_no_wr", 32'(bus.fifo_wr_en), 0);
      tick(); tick();
      chk("tie_r_tx_start", 32'(bus.tx_start), 1);
      chk("tie_r_tx_din", 32'(bus.tx_din), 32'(r));
      tick();
      bus.tx_done_tick = 1'b1;
      tick();
      bus.tx_done_tick = 1'b0;
      chk("tie_r_wr_pending", 32'(bus.busy), 1);
      chk("tie_r_no_wr_yet", 32'(bus.fifo_wr_en), 0);
      tick();
      chk("tie_r_then_wr", 32'(bus.fifo_wr_en), 1);
      chk("tie_r_then_data", 32'(bus.fifo_w_data), 32'(d));
      tick();
      chk("tie_r_done", 32'(bus.busy), 0);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    bus.wr_pulse = 1'b0; bus.rd_pulse = 1'b0;
    bus.sw_data = '0; bus.tx_done_tick = 1'b0;
    tick();
    do_reset();
    chk_all_zero("reset");

    do_op(1'b1, 8'hA5, 1'b0, 8'h00, 0);
    do_op(1'b0, 8'h00, 1'b0, 8'h3C, 100);

    tie(1'b1, 8'h11, 8'h22);
    do_op(1'b1, 8'h33, 1'b0, 8'h00, 0);
    tie(1'b0, 8'h44, 8'h55);

    do_op(1'b1, 8'h66, 1'b1, 8'h00, 0);
    do_op(1'b0, 8'h00, 1'b1, 8'h00, 0);
    for (int i = 0; i < 300; i++) do_op(i[0], 8'(i), 1'b1, 8'h00, 0);
    chk("err_saturated", 32'(bus.err_count), 255);

    // A write arriving while the UART frame is in flight waits for tx_done_tick.
    dir_full = 1'b0; dir_empty = 1'b0; dir_rdata = 8'h5A;
    bus.sw_data = 8'hC3;
    bus.rd_pulse = 1'b1;
    tick(); bus.rd_pulse = 1'b0;
    tick(); tick(); tick();
    chk("wd_tx_start", 32'(bus.tx_start), 1);
    tick();
    bus.wr_pulse = 1'b1;
    tick(); bus.wr_pulse = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("wd_held_no_wr", 32'(bus.fifo_wr_en), 0);
      chk("wd_held_busy", 32'(bus.busy), 1);
    end
    bus.tx_done_tick = 1'b1;
    tick(); bus.tx_done_tick = 1'b0;
    chk("wd_idle_no_wr", 32'(bus.fifo_wr_en), 0);
    tick();
    chk("wd_wr_after_done", 32'(bus.fifo_wr_en), 1);
    chk("wd_wr_data", 32'(bus.fifo_w_data), 32'hC3);
    tick();
    chk("wd_busy_drop", 32'(bus.busy), 0);

    // Reset in the middle of a frame; the late done tick must be ignored.
    dir_rdata = 8'h77;
    bus.rd_pulse = 1'b1;
    tick(); bus.rd_pulse = 1'b0;
    tick(); tick(); tick(); tick();
    chk("rw_pre_busy", 32'(bus.busy), 1);
    do_reset();
    chk_all_zero("rst_wait");
    bus.tx_done_tick = 1'b1;
    tick(); bus.tx_done_tick = 1'b0;
    chk_all_zero("late_done");
    tick();
    chk_all_zero("late_done2");

    // Random single requests against the FIFO model.
    use_emu = 1'b1;
    tick();
    for (int i = 0; i < 80; i++) begin
      bit is_wr;
      bit flag;
      logic [7:0] rexp;
      is_wr = (i < 40) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 3);
      flag  = is_wr ? (exp_q.size() == DEPTH) : (exp_q.size() == 0);
      rexp  = (!is_wr && exp_q.size() > 0) ? exp_q[0] : 8'h00;
      do_op(is_wr, 8'($urandom()), flag, rexp, int'($urandom_range(1, 6)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
